uart_program_loader: RTL
========================

Name: uart_program_loader

Overview:
Boot-time program loader that sits directly upstream of the CPU core's instruction memory in cpu_uart_top. It deserialises an 8N1 UART byte stream and packs bytes little-endian into 32-bit words. Each word is written into consecutive instruction-memory cells from address 0. After CELL_NUMBERS words it raises load_done, which releases the CPU from hold so execution starts at pc = 0.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); benches use 4
CELL_NUMBERS, 64, number of 32-bit words loaded before load_done
ADDR_WIDTH, 6, width of mem_addr; must satisfy 2**ADDR_WIDTH >= CELL_NUMBERS

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
uart_rx  in  1  serial input, idle high, asynchronous to clk
mem_we  out  1  one-cycle write strobe to instruction memory
mem_addr  out  ADDR_WIDTH  word address of the current write
mem_wdata  out  32  word being written
load_done  out  1  sticky; 1 = program fully loaded, CPU may run
frame_err  out  1  sticky; set on any stop-bit error
byte_cnt  out  2  index of the next byte within the current word (debug)

Behaviour:
- Reset (rst = 0, asynchronous): mem_we = 0, mem_addr = 0, mem_wdata = 0, load_done = 0, frame_err = 0, byte_cnt = 0.
  - Synchroniser flops reset to 1; RX FSM goes to IDLE.
  - A partially received byte or word is discarded; reloading restarts at address 0.
- Input: uart_rx passes through a 2-flop synchroniser; all RX logic uses the synchronised value rx_s.
- RX FSM, with a bit timer counting 0..CLKS_PER_BIT-1:
  - IDLE: on rx_s = 0, go to START and clear the timer.
  - START: at timer = CLKS_PER_BIT/2 - 1 (mid start bit), if rx_s = 0 go to DATA with timer cleared; if rx_s = 1 it is a glitch, return to IDLE.
  - DATA: sample rx_s each time the timer reaches CLKS_PER_BIT-1 and shift LSB-first. After bit 7, go to STOP.
  - STOP: at timer = CLKS_PER_BIT-1, if rx_s = 1 emit a one-cycle internal byte_valid and go to IDLE. If rx_s = 0, set frame_err, drop the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s = 1, then go to IDLE.
- Word assembly, on byte_valid while load_done = 0:
  - byte_cnt = k writes the byte into word bits [8k+7:8k]; byte_cnt then increments and wraps 3 -> 0.
  - On the 4th byte (byte_cnt = 3), the next cycle drives mem_we = 1 for exactly one cycle, with mem_wdata = the assembled word and mem_addr = the current word index.
  - The word index increments in the cycle after the strobe.
  - Latency: mem_we is asserted 1 clk after the stop-bit sample of byte 3.
- Completion:
  - In the same cycle as the write of word CELL_NUMBERS-1, load_done goes to 1 on the next edge and stays 1 until reset.
  - mem_addr wraps to 0.
- After load_done:
  - Further bytes are still deserialised (frame_err still updates).
  - They cause no mem_we, and byte_cnt freezes.
- mem_wdata and mem_addr hold their last values when mem_we = 0.
- frame_err does not block loading; subsequent valid bytes continue to be packed.
- A new start bit arriving during STOP processing is not possible at the specified timing; IDLE re-arms in the cycle after the STOP decision.

Test Plan:
- Reset and idle:
  - Hold rst = 0 for 5 cycles, then release with uart_rx = 1 for 100 cycles.
  - Required: mem_we never 1, load_done = 0, frame_err = 0, mem_addr = 0.
- Single word (CLKS_PER_BIT = 4, CELL_NUMBERS = 2):
  - Send bytes 0x13, 0x05, 0x10, 0x00.
  - Required: exactly one mem_we pulse with mem_addr = 0, mem_wdata = 0x00100513; byte_cnt back to 0; load_done = 0.
- Full load:
  - Send 8 bytes forming words 0x00100513 and 0x00000593.
  - Required: second pulse at mem_addr = 1 with mem_wdata = 0x00000593; load_done = 1 one cycle later.
  - Required: a 9th byte 0xFF produces no mem_we.
- Framing error:
  - Send 0xAA with stop bit = 0, then 0x11, 0x22, 0x33, 0x44.
  - Required: frame_err = 1, sticky; 0xAA dropped; word written = 0x44332211 at addr 0.
- Glitch rejection:
  - Pulse uart_rx low for 1 cycle, less than half a bit.
  - Required: FSM returns to IDLE, byte_cnt unchanged, no mem_we.
- Reset mid-word:
  - Send 2 bytes, assert rst for 3 cycles, release, then send 0x01, 0x02, 0x03, 0x04.
  - Required: mem_we at addr 0 with mem_wdata = 0x04030201.

Source files
------------

// File: rtl/uart_program_loader_if.sv
// uart_program_loader_if
//   Connects the program loader to its surroundings: the serial input, the
//   instruction-memory write port and the loader status flags.
//
//   master : the loader side. It takes uart_rx and drives everything else.
//   slave  : the memory/CPU side. It drives uart_rx and observes the rest.
//
//   Signals
//     uart_rx    serial input. Idle level is high.
//     mem_we     one-cycle write strobe to instruction memory
//     mem_addr   word address of the current write
//     mem_wdata  word being written
//     load_done  sticky. The program is loaded and the CPU may run.
//     frame_err  sticky. A stop-bit error has been seen.
//     byte_cnt   index of the next byte within the current word (debug)
interface uart_program_loader_if #(
    parameter int ADDR_WIDTH = 6
);
    logic                  uart_rx;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  load_done;
    logic                  frame_err;
    logic [1:0]            byte_cnt;

    modport master (
        input  uart_rx,
        output mem_we, mem_addr, mem_wdata, load_done, frame_err, byte_cnt
    );

    modport slave (
        output uart_rx,
        input  mem_we, mem_addr, mem_wdata, load_done, frame_err, byte_cnt
    );
endinterface

// File: rtl/uart_program_loader.sv
// uart_program_loader
//   Boot-time program loader. It receives an 8N1 UART byte stream and packs
//   the bytes little-endian into 32-bit words. Each word is written to
//   consecutive instruction-memory cells, starting at address 0. After
//   CELL_NUMBERS words it raises load_done, which releases the CPU from hold.
//
//   Ports
//     clk   system clock. All logic runs on the rising edge.
//     rst   asynchronous reset, active low
//     bus   uart_program_loader_if.master, which carries:
//             uart_rx, mem_we, mem_addr, mem_wdata, load_done, frame_err,
//             byte_cnt
//
//   Parameters
//     CLKS_PER_BIT  clk cycles per UART bit. Must be 2 or more.
//     CELL_NUMBERS  number of words loaded before load_done
//     ADDR_WIDTH    width of mem_addr. Requires 2**ADDR_WIDTH >= CELL_NUMBERS.
module uart_program_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CELL_NUMBERS = 64,
    parameter int ADDR_WIDTH   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_program_loader_if.master bus
);
    localparam int TIMER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TIMER_W-1:0]    BIT_LAST  = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [TIMER_W-1:0]    HALF_LAST = TIMER_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_CELL = ADDR_WIDTH'(CELL_NUMBERS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_t;

    // ------------------------------------------------------------------
    // Input synchroniser. The flops reset to the line's idle level so that
    // the FSM does not see a phantom start bit when reset is released.
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rx_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make the two flops shift in one
            // edge. Blocking assignments would collapse them into a single
            // flop.
            rx_meta <= bus.uart_rx;
            rx_s    <= rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // RX FSM. The START state checks the middle of the start bit. Every
    // later sample is taken one full bit period after the previous one, so
    // each sample lands near the centre of its bit.
    // ------------------------------------------------------------------
    rx_state_t          state;
    logic [TIMER_W-1:0] timer;
    logic [2:0]         bit_idx;
    logic [7:0]         shift_reg;
    logic [7:0]         byte_data;
    logic               byte_valid;
    logic               frame_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            timer      <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state <= ST_START;
                        timer <= '0;
                    end
                end
                ST_START: begin
                    if (timer == HALF_LAST) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        // A line that is high again by mid-bit is a glitch,
                        // not a start bit.
                        state   <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (timer == BIT_LAST) begin
                        timer     <= '0;
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        bit_idx   <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= ST_STOP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (timer == BIT_LAST) begin
                        timer <= '0;
                        if (rx_s) begin
                            byte_data  <= shift_reg;
                            byte_valid <= 1'b1;
                            state      <= ST_IDLE;
                        end else begin
                            // Bad stop bit. Drop the byte and wait for the
                            // line to go idle before arming for a new start
                            // bit.
                            frame_err <= 1'b1;
                            state     <= ST_WAIT_IDLE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (rx_s) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Word assembly and memory write. The write strobe comes from the fourth
    // byte_valid. The word index then advances on the cycle after the
    // strobe.
    // ------------------------------------------------------------------
    logic [23:0]           word_buf;
    logic [1:0]            byte_cnt;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  load_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: word_buf is a plain register, not a memory array. It is
            // reset together with the other state so that a word cut off by
            // reset cannot leak bytes into the next load.
            word_buf  <= '0;
            byte_cnt  <= '0;
            word_idx  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            load_done <= 1'b0;
        end else begin
            mem_we <= 1'b0;

            if (byte_valid && !load_done) begin
                byte_cnt <= byte_cnt + 1'b1;
                if (byte_cnt == 2'd3) begin
                    mem_we    <= 1'b1;
                    mem_wdata <= {byte_data, word_buf};
                    mem_addr  <= word_idx;
                end else begin
                    word_buf[8*byte_cnt +: 8] <= byte_data;
                end
            end

            if (mem_we) begin
                if (word_idx == LAST_CELL) begin
                    word_idx  <= '0;
                    mem_addr  <= '0;
                    load_done <= 1'b1;
                end else begin
                    word_idx <= word_idx + 1'b1;
                end
            end
        end
    end

    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.load_done = load_done;
    assign bus.frame_err = frame_err;
    assign bus.byte_cnt  = byte_cnt;
endmodule
